ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Parametrised, elastic EX/MEM pipeline stage. It registers the execute-stage result bundle (write-back controls, ALU result, store data, destination register, memory controls) and presents it to the memory stage. A valid/ready handshake on both sides and a two-entry skid buffer let a variable-latency data memory back-pressure EX without a combinational ready path. Bubbles carry zeroed control bits, so a stalled or flushed slot never writes memory or the register file.

## Interface
- DATA_W, 32, width of ALU result and store data
- REG_W, 5, width of destination register index
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- valid_i  in  1  EX presents a bundle this cycle
- ready_o  out  1  stage can accept a bundle; equals NOT skid_valid (registered source)
- WB_i  in  2  [1]=RegWrite, [0]=MemToReg
- ALUOut_i  in  DATA_W  ALU result / memory address
- mux7_i  in  DATA_W  store data (forwarded RT)
- mux8_i  in  REG_W  destination register
- MemRead_i, MemWrite_i  in  1 each  memory controls
- flush_i  in  1  kill all held bundles (present only with EX_MEM_FLUSH_EN)
- valid_o  out  1  MEM-side bundle valid
- ready_i  in  1  MEM accepts the bundle
- WB_o, ALUOut_o, mux7_o, mux8_o, MemRead_o, MemWrite_o  out  as inputs  head bundle

## Operation
- Storage: main entry (drives outputs) and skid entry, each with a valid bit.
- Accept: valid_i && ready_o. Deliver: valid_o && ready_i.
- Main empty, or delivering this cycle: accepted bundle loads main; if skid is valid it moves to main first and the new bundle goes to skid.
- Main holding, not delivering, accept: bundle goes to skid; ready_o drops next cycle.
- Delivering with skid valid: skid moves to main, skid empties.
- Delivering with nothing accepted and skid empty: main valid clears.
- Bundles leave in arrival order. None is duplicated or lost.
- Output gating: when valid_o=0, WB_o=2'b00, MemRead_o=0, MemWrite_o=0. ALUOut_o, mux7_o and mux8_o hold their last value.
- Upstream must hold the bundle stable while valid_i && !ready_o. The stage does not check this.

## Timing
- Reset (rst_i low, asynchronous): both valids 0, all data registers 0. Outputs: valid_o=0, ready_o=1, all bundle outputs 0. Release is synchronous to clk_i.
- Latency: 1 cycle from accept to valid_o.
- Throughput: 1 bundle per cycle while ready_i=1.
- ready_o depends only on registered state; there is no combinational path from ready_i.
- Sustained ready_i=0: one bundle is accepted into main and a second into skid. ready_o is then low from the cycle after the skid fills.
- Flush: synchronous and highest priority. Both valids clear next edge, and a same-cycle valid_i is dropped (upstream sees it consumed because ready_o is high). Outputs are gated the cycle after flush.
- Reset asserted mid-transfer: all entries are discarded immediately.

## Configuration
- EX_MEM_FLUSH_EN defined: flush_i port exists with the behaviour above.
- EX_MEM_FLUSH_EN undefined: no flush_i port, and entries clear only by delivery or reset. All other behaviour is identical.

## Test plan
- Reset: drive rst_i=0 mid-cycle with both entries full -> valid_o=0, ready_o=1 and all outputs 0 immediately, with no clock edge needed.
- Streaming: ready_i=1, 8 back-to-back bundles with ALUOut_i=0..7 -> valid_o from cycle 1, ALUOut_o=0..7 in consecutive cycles, ready_o constantly 1.
- Back-pressure: ready_i=0 while sending A=0x10 and B=0x20 -> ready_o=0 after B; then ready_i=1 -> A then B delivered in order, and C=0x30 offered during the stall is accepted only after ready_o rises.
- Bubble gating: valid_i=0 with WB_i=2'b11, MemWrite_i=1 -> valid_o=0, WB_o=0, MemWrite_o=0.
- Flush (macro on): both entries full, flush_i=1 with valid_i=1 -> next cycle valid_o=0, ready_o=1, and the flushed input never appears.
- Macro off: same stimulus without flush -> both held bundles delivered in order once ready_i=1.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: elastic EX/MEM pipeline register with a two-entry skid buffer.
// Main entry drives the MEM-side outputs; the skid entry absorbs one bundle
// when MEM stalls so that ready_o comes straight from a flop.
// Optional flush port: define EX_MEM_FLUSH_EN to add flush_i.
module ex_mem_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        WB_i,
  input  logic [DATA_W-1:0] ALUOut_i,
  input  logic [DATA_W-1:0] mux7_i,
  input  logic [REG_W-1:0]  mux8_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
`ifdef EX_MEM_FLUSH_EN
  input  logic              flush_i,
`endif
  output logic              valid_o,
  input  logic              ready_i,
  output logic [1:0]        WB_o,
  output logic [DATA_W-1:0] ALUOut_o,
  output logic [DATA_W-1:0] mux7_o,
  output logic [REG_W-1:0]  mux8_o,
  output logic              MemRead_o,
  output logic              MemWrite_o
);

  typedef struct packed {
    logic [1:0]        wb;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] st;
    logic [REG_W-1:0]  rd;
    logic              mem_read;
    logic              mem_write;
  } bundle_t;

  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  bundle_t in_c;
  logic    main_valid_q, main_valid_d;
  logic    skid_valid_q, skid_valid_d;
  logic    ready_q, ready_d;
  logic    accept_c;
  logic    deliver_c;
  logic    flush_c;

`ifdef EX_MEM_FLUSH_EN
  assign flush_c = flush_i;
`else
  assign flush_c = 1'b0;
`endif

  // Pack the incoming EX bundle.
  always_comb begin
    in_c           = '0;
    in_c.wb        = WB_i;
    in_c.alu       = ALUOut_i;
    in_c.st        = mux7_i;
    in_c.rd        = mux8_i;
    in_c.mem_read  = MemRead_i;
    in_c.mem_write = MemWrite_i;
  end

  // Next-state for main/skid entries; control bits of an empty main are zeroed.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    accept_c     = valid_i & ready_q;
    deliver_c    = main_valid_q & ready_i;

    if (flush_c) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || deliver_c) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = accept_c;
        if (accept_c) begin
          skid_d = in_c;
        end
      end else begin
        main_valid_d = accept_c;
        if (accept_c) begin
          main_d = in_c;
        end
      end
    end else if (accept_c) begin
      skid_d       = in_c;
      skid_valid_d = 1'b1;
    end

    if (!main_valid_d) begin
      main_d.wb        = 2'b00;
      main_d.mem_read  = 1'b0;
      main_d.mem_write = 1'b0;
    end

    ready_d = ~skid_valid_d;
  end

  // State registers; reset discards both entries at once.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

  assign ready_o    = ready_q;
  assign valid_o    = main_valid_q;
  assign WB_o       = main_q.wb;
  assign ALUOut_o   = main_q.alu;
  assign mux7_o     = main_q.st;
  assign mux8_o     = main_q.rd;
  assign MemRead_o  = main_q.mem_read;
  assign MemWrite_o = main_q.mem_write;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage: directed scenarios plus randomized traffic
// checked against a queue-based model of a two-deep in-order buffer.
module tb_ex_mem_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef struct packed {
    logic [1:0]        wb;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] st;
    logic [REG_W-1:0]  rd;
    logic              mr;
    logic              mw;
  } bundle_t;

  logic clk;
  logic rst_i;
  logic valid_i;
  logic ready_i;
  logic flush_i;
  bundle_t in_b;

  logic              ready_o, valid_o;
  logic [1:0]        WB_o;
  logic [DATA_W-1:0] ALUOut_o, mux7_o;
  logic [REG_W-1:0]  mux8_o;
  logic              MemRead_o, MemWrite_o;

  int checks = 0;
  int errors = 0;

  // Model: FIFO of held bundles (capacity 2) plus the last head's data fields.
  bundle_t q[$];
  bundle_t last;
  logic    stalled;

  ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .WB_i      (in_b.wb),
    .ALUOut_i  (in_b.alu),
    .mux7_i    (in_b.st),
    .mux8_i    (in_b.rd),
    .MemRead_i (in_b.mr),
    .MemWrite_i(in_b.mw),
`ifdef EX_MEM_FLUSH_EN
    .flush_i   (flush_i),
`endif
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .WB_o      (WB_o),
    .ALUOut_o  (ALUOut_o),
    .mux7_o    (mux7_o),
    .mux8_o    (mux8_o),
    .MemRead_o (MemRead_o),
    .MemWrite_o(MemWrite_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b.wb  = 2'($urandom_range(0, 3));
    b.alu = $urandom;
    b.st  = $urandom;
    b.rd  = 5'($urandom_range(0, 31));
    b.mr  = 1'($urandom_range(0, 1));
    b.mw  = 1'($urandom_range(0, 1));
    return b;
  endfunction

  function automatic bundle_t mk(input logic [DATA_W-1:0] alu);
    bundle_t b;
    b.wb  = 2'b11;
    b.alu = alu;
    b.st  = ~alu;
    b.rd  = alu[4:0];
    b.mr  = 1'b0;
    b.mw  = 1'b1;
    return b;
  endfunction

  // One clock: advance the model with the inputs present at the edge.
  task automatic tick();
    int   pre;
    logic acc, del, fl;
    pre = q.size();
`ifdef EX_MEM_FLUSH_EN
    fl = flush_i;
`else
    fl = 1'b0;
`endif
    acc = valid_i && (pre < 2);
    del = ready_i && (pre > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (del) void'(q.pop_front());
      if (acc) q.push_back(in_b);
    end
    if (q.size() > 0) last = q[0];
    stalled = valid_i && !acc && !fl;
    @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    last    = '0;
    stalled = 1'b0;
  endtask

  task automatic test_reset();
    // Values after the initial reset
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || ALUOut_o !== '0 || WB_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_init: valid=%b ready=%b alu=%h wb=%b, required 0 1 0 00",
               valid_o, ready_o, ALUOut_o, WB_o);
    end
    // Fill both entries, then assert reset between edges
    ready_i = 1'b0;
    valid_i = 1'b1; in_b = mk(32'hA5A5_0001); tick();
    in_b = mk(32'hA5A5_0002); tick();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_fill: valid=%b ready=%b, required 1 0", valid_o, ready_o);
    end
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || WB_o !== 2'b00 || ALUOut_o !== '0 ||
        mux7_o !== '0 || mux8_o !== '0 || MemRead_o !== 1'b0 || MemWrite_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: valid=%b ready=%b wb=%b alu=%h st=%h rd=%h mr=%b mw=%b, required all 0 with ready=1",
               valid_o, ready_o, WB_o, ALUOut_o, mux7_o, mux8_o, MemRead_o, MemWrite_o);
    end
    model_reset();
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_streaming();
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid_i = 1'b1;
      in_b = mk(32'(i));
      tick();
      checks++;
      if (valid_o !== 1'b1 || ALUOut_o !== 32'(i) || ready_o !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: valid=%b alu=%h ready=%b, required 1 %h 1",
                 i, valid_o, ALUOut_o, ready_o, i);
      end
    end
    valid_i = 1'b0;
    tick();
    checks++;
    if (valid_o !== 1'b0 || WB_o !== 2'b00 || MemWrite_o !== 1'b0 || ALUOut_o !== 32'd7) begin
      errors++;
      $display("FAIL stream_drain: valid=%b wb=%b mw=%b alu=%h, required 0 00 0 7",
               valid_o, WB_o, MemWrite_o, ALUOut_o);
    end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    valid_i = 1'b1; in_b = mk(32'h10); tick();
    checks++;
    if (valid_o !== 1'b1 || ALUOut_o !== 32'h10 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_a: valid=%b alu=%h ready=%b, required 1 10 1", valid_o, ALUOut_o, ready_o);
    end
    in_b = mk(32'h20); tick();
    checks++;
    if (ready_o !== 1'b0 || ALUOut_o !== 32'h10) begin
      errors++;
      $display("FAIL bp_b: ready=%b alu=%h, required 0 10", ready_o, ALUOut_o);
    end
    in_b = mk(32'h30); tick();
    checks++;
    if (ready_o !== 1'b0 || ALUOut_o !== 32'h10 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: ready=%b alu=%h valid=%b, required 0 10 1", ready_o, ALUOut_o, valid_o);
    end
    ready_i = 1'b1; tick();
    checks++;
    if (ALUOut_o !== 32'h20 || ready_o !== 1'b1 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_b_out: alu=%h ready=%b valid=%b, required 20 1 1", ALUOut_o, ready_o, valid_o);
    end
    tick();
    checks++;
    if (ALUOut_o !== 32'h30 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_c_out: alu=%h valid=%b, required 30 1", ALUOut_o, valid_o);
    end
    valid_i = 1'b0; tick();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain: valid=%b ready=%b, required 0 1", valid_o, ready_o);
    end
  endtask

  task automatic test_bubble();
    ready_i = 1'b1;
    valid_i = 1'b0;
    in_b = mk(32'h55);
    in_b.mr = 1'b1;
    tick();
    checks++;
    if (valid_o !== 1'b0 || WB_o !== 2'b00 || MemWrite_o !== 1'b0 || MemRead_o !== 1'b0) begin
      errors++;
      $display("FAIL bubble: valid=%b wb=%b mw=%b mr=%b, required 0 00 0 0",
               valid_o, WB_o, MemWrite_o, MemRead_o);
    end
  endtask

  task automatic test_flush();
    ready_i = 1'b0;
    valid_i = 1'b1; in_b = mk(32'h41); tick();
    in_b = mk(32'h42); tick();
`ifdef EX_MEM_FLUSH_EN
    flush_i = 1'b1;
    in_b = mk(32'hDEAD);
    tick();
    flush_i = 1'b0;
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || WB_o !== 2'b00 || MemWrite_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_now: valid=%b ready=%b wb=%b mw=%b, required 0 1 00 0",
               valid_o, ready_o, WB_o, MemWrite_o);
    end
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_after_%0d: valid=%b alu=%h, required valid 0", i, valid_o, ALUOut_o);
      end
    end
`else
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    checks++;
    if (valid_o !== 1'b1 || ALUOut_o !== 32'h42) begin
      errors++;
      $display("FAIL noflush_second: valid=%b alu=%h, required 1 42", valid_o, ALUOut_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL noflush_drain: valid=%b ready=%b, required 0 1", valid_o, ready_o);
    end
`endif
  endtask

  task automatic test_random();
    bundle_t exp;
    logic    exp_v, exp_r;
    stalled = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!stalled) begin
        valid_i = ($urandom_range(0, 3) != 0);
        in_b    = rand_bundle();
      end
      ready_i = (n % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
`ifdef EX_MEM_FLUSH_EN
      flush_i = ($urandom_range(0, 29) == 0);
`endif
      tick();
      exp_v = (q.size() > 0);
      exp_r = (q.size() < 2);
      exp   = exp_v ? q[0] : last;
      if (!exp_v) begin
        exp.wb = 2'b00; exp.mr = 1'b0; exp.mw = 1'b0;
      end
      checks++;
      if (valid_o !== exp_v || ready_o !== exp_r) begin
        errors++;
        $display("FAIL rand_hs_%0d: valid=%b ready=%b, required %b %b", n, valid_o, ready_o, exp_v, exp_r);
      end
      checks++;
      if (WB_o !== exp.wb || MemRead_o !== exp.mr || MemWrite_o !== exp.mw) begin
        errors++;
        $display("FAIL rand_ctl_%0d: wb=%b mr=%b mw=%b, required %b %b %b",
                 n, WB_o, MemRead_o, MemWrite_o, exp.wb, exp.mr, exp.mw);
      end
      checks++;
      if (ALUOut_o !== exp.alu || mux7_o !== exp.st || mux8_o !== exp.rd) begin
        errors++;
        $display("FAIL rand_data_%0d: alu=%h st=%h rd=%h, required %h %h %h",
                 n, ALUOut_o, mux7_o, mux8_o, exp.alu, exp.st, exp.rd);
      end
    end
`ifdef EX_MEM_FLUSH_EN
    flush_i = 1'b0;
`endif
    valid_i = 1'b0;
  endtask

  initial begin
    rst_i   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    flush_i = 1'b0;
    in_b    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);

    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
